// File: rtl/fetch_decode_buffer_pkg.sv
// Shared widths, state encoding and payload type for the fetch/decode buffer.
package fetch_decode_buffer_pkg;

    localparam int unsigned FDB_WORD    = 64;
    localparam int unsigned FDB_INSTR_W = 32;
    localparam int unsigned FDB_CYCLE   = 10;

    typedef enum logic [1:0] {
        FDB_EMPTY = 2'd0,
        FDB_ONE   = 2'd1,
        FDB_FULL  = 2'd2
    } fdb_state_e;

    typedef struct packed {
        logic [FDB_WORD-1:0]    pc;
        logic [FDB_INSTR_W-1:0] instr;
    } fdb_entry_t;

endpackage

// File: rtl/fetch_decode_buffer_enable_register.sv
// D flip-flop bank with synchronous clear and load enable.
module enable_register #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/fetch_decode_buffer.sv
// Two-entry skid buffer between fetch and decode; all handshake outputs come
// straight from flops, so out_ready has no combinational path to in_ready.
module fetch_decode_buffer
    import fetch_decode_buffer_pkg::*;
#(
    parameter int unsigned WORD    = FDB_WORD,
    parameter int unsigned INSTR_W = FDB_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         occupancy
);

    fdb_state_e         state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic [1:0]         occupancy_q, occupancy_d;

    logic               accept;
    logic               take;
    logic               main_en;
    logic               skid_en;
    logic               main_from_skid;

    logic [WORD-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [WORD-1:0]    skid_pc_q;
    logic [INSTR_W-1:0] skid_instr_q;

    assign accept = in_valid & in_ready_q;
    assign take   = out_valid_q & out_ready;

    // State and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FDB_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            occupancy_q <= occupancy_d;
        end
    end

    // Next state, data-stage load enables and next-cycle output values
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;

        unique case (state_q)
            FDB_EMPTY: begin
                if (accept) begin
                    state_d = FDB_ONE;
                    main_en = 1'b1;
                end
            end
            FDB_ONE: begin
                if (accept && take) begin
                    main_en = 1'b1;
                end else if (accept) begin
                    state_d = FDB_FULL;
                    skid_en = 1'b1;
                end else if (take) begin
                    state_d = FDB_EMPTY;
                end
            end
            FDB_FULL: begin
                if (take) begin
                    state_d        = FDB_ONE;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = FDB_EMPTY;
        endcase

        // Flush drops everything, including a pair handshaked this cycle
        if (flush) begin
            state_d = FDB_EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end

        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        occupancy_d = 2'd0;
        unique case (state_d)
            FDB_ONE: begin
                out_valid_d = 1'b1;
                occupancy_d = 2'd1;
            end
            FDB_FULL: begin
                out_valid_d = 1'b1;
                in_ready_d  = 1'b0;
                occupancy_d = 2'd2;
            end
            default: ;
        endcase

        main_pc_d    = main_from_skid ? skid_pc_q    : in_pc;
        main_instr_d = main_from_skid ? skid_instr_q : in_instr;
    end

    enable_register #(.W(WORD)) u_main_pc (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_pc_d),
        .q     (main_pc_q)
    );

    enable_register #(.W(INSTR_W)) u_main_instr (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_instr_d),
        .q     (main_instr_q)
    );

    enable_register #(.W(WORD)) u_skid_pc (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_pc),
        .q     (skid_pc_q)
    );

    enable_register #(.W(INSTR_W)) u_skid_instr (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_instr),
        .q     (skid_instr_q)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign occupancy = occupancy_q;
    assign out_pc    = main_pc_q;
    assign out_instr = main_instr_q;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Bench for fetch_decode_buffer: directed vector table, hand-written corner
// sequences and a random stream, all backed by a FIFO scoreboard.
module tb_fetch_decode_buffer;
    import fetch_decode_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    fdb_entry_t sb_q[$];

    always #(FDB_CYCLE/2) clk = ~clk;

    fetch_decode_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .occupancy (occupancy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the clock and update/check the scoreboard.
    task automatic step(input logic rst, input logic iv, input logic [63:0] pc,
                        input logic [31:0] ins, input logic ordy, input logic fl);
        logic acc, tk;
        @(negedge clk);
        reset     = rst;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        #1;
        acc = in_valid & in_ready;
        tk  = out_valid & out_ready;
        if (tk && !rst) begin
            if (sb_q.size() == 0) begin
                chk("sb_take_on_empty", 64'(out_valid), 64'd0);
            end else begin
                chk("sb_head_pc", out_pc, sb_q[0].pc);
                chk("sb_head_instr", 64'(out_instr), 64'(sb_q[0].instr));
            end
        end
        @(posedge clk);
        #1;
        if (rst || fl) begin
            sb_q.delete();
        end else begin
            if (tk && sb_q.size() != 0) void'(sb_q.pop_front());
            if (acc) sb_q.push_back('{pc: pc, instr: ins});
        end
        chk("sb_out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
        chk("sb_occupancy", 64'(occupancy), 64'(sb_q.size()));
        chk("sb_in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
        if (sb_q.size() != 0) chk("sb_out_pc", out_pc, sb_q[0].pc);
    endtask

    typedef struct {
        logic        rst;
        logic        iv;
        logic [63:0] pc;
        logic [31:0] ins;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic        er;
        logic [1:0]  eo;
        logic [63:0] epc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // rst iv pc ins ordy fl | valid ready occ pc (after the edge)
        vecs.push_back('{1'b1, 1'b0, 64'h00, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 64'h00});
        vecs.push_back('{1'b0, 1'b1, 64'h00, 32'h8B020020,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'h00});
        vecs.push_back('{1'b0, 1'b1, 64'h04, 32'hCB020020,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'h04});
        vecs.push_back('{1'b0, 1'b1, 64'h08, 32'hF8400020,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'h08});
        vecs.push_back('{1'b0, 1'b0, 64'h00, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 64'h08});
        vecs.push_back('{1'b0, 1'b1, 64'h10, 32'h10000010,  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 64'h10});
        vecs.push_back('{1'b0, 1'b1, 64'h14, 32'h10000014,  1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 64'h10});
        vecs.push_back('{1'b0, 1'b1, 64'h18, 32'h10000018,  1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 64'h10});
        vecs.push_back('{1'b0, 1'b1, 64'h18, 32'h10000018,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'h14});
        vecs.push_back('{1'b0, 1'b1, 64'h18, 32'h10000018,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'h18});
        vecs.push_back('{1'b0, 1'b0, 64'h00, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 64'h18});
        vecs.push_back('{1'b0, 1'b1, 64'h20, 32'h10000020,  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 64'h20});
        vecs.push_back('{1'b0, 1'b1, 64'h24, 32'h10000024,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 64'h24});
        vecs.push_back('{1'b0, 1'b0, 64'h00, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 64'h24});

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].iv, vecs[i].pc, vecs[i].ins, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].ev));
            chk($sformatf("vec%0d_ready", i), 64'(in_ready), 64'(vecs[i].er));
            chk($sformatf("vec%0d_occ", i), 64'(occupancy), 64'(vecs[i].eo));
            chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].epc);
        end
        chk("reset_instr_cleared_then_loaded", 64'(out_instr), 64'h10000024);

        // Flush while FULL with a pair on the input
        step(1'b0, 1'b1, 64'h30, 32'h10000030, 1'b0, 1'b0);
        chk("pre_flush_occ", 64'(occupancy), 64'd2);
        step(1'b0, 1'b1, 64'h40, 32'h10000040, 1'b0, 1'b1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        step(1'b0, 1'b1, 64'h100, 32'h10000100, 1'b0, 1'b0);
        chk("post_flush_head", out_pc, 64'h100);

        // Flush in ONE with a simultaneous accept: incoming pair must be dropped
        step(1'b0, 1'b1, 64'h104, 32'h10000104, 1'b0, 1'b1);
        chk("flush_one_valid", 64'(out_valid), 64'd0);
        chk("flush_one_pc_kept", out_pc, 64'h100);
        step(1'b0, 1'b1, 64'h100, 32'h10000100, 1'b0, 1'b0);

        // Reset mid-stream from FULL, released a fifth of a cycle after the edge
        step(1'b0, 1'b1, 64'h200, 32'h10000200, 1'b0, 1'b0);
        chk("pre_reset_occ", 64'(occupancy), 64'd2);
        @(negedge clk);
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 64'h300;
        in_instr  = 32'h10000300;
        @(posedge clk);
        #(FDB_CYCLE/5);
        sb_q.delete();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        chk("rst_instr", 64'(out_instr), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_occ", 64'(occupancy), 64'd0);
        reset = 1'b0;
        step(1'b0, 1'b1, 64'h300, 32'h10000300, 1'b0, 1'b0);
        chk("post_rst_first", out_pc, 64'h300);
        chk("post_rst_first_instr", 64'(out_instr), 64'h10000300);

        // Drain ONE to EMPTY: data holds its last value
        step(1'b0, 1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_pc_hold", out_pc, 64'h300);
        chk("drain_instr_hold", 64'(out_instr), 64'h10000300);

        // Random stream against the scoreboard
        for (int n = 0; n < 400; n++) begin
            step(1'b0, 1'($urandom_range(0, 1)), {32'h0, $urandom}, $urandom,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end
        for (int n = 0; n < 4 && sb_q.size() != 0; n++) begin
            step(1'b0, 1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        end
        chk("final_drained", 64'(occupancy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(FDB_CYCLE * 5000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
- Decode-side receiving end of the fetch interface.
- Accepts {PC, instruction} pairs from the fetch stage over a valid/ready handshake and presents them to decode with registered outputs.
- Two-entry skid buffer (main + skid): sustains one transfer per cycle, fully registered, no combinational path from out_ready to in_ready.
- Supports pipeline flush for taken branches.

Parameters:
- WORD, `WORD (64), width of PC.
- INSTR_W, 32, instruction width.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents a valid pair
- in_ready  out  1  buffer can accept; registered
- in_pc  in  WORD  PC of fetched instruction
- in_instr  in  INSTR_W  fetched instruction word
- flush  in  1  discard all held and incoming entries this cycle
- out_valid  out  1  entry available to decode; registered
- out_ready  in  1  decode consumes entry this cycle
- out_pc  out  WORD  PC of head entry
- out_instr  out  INSTR_W  instruction of head entry
- occupancy  out  2  number of held entries, 0..2

Behaviour:
- Handshakes:
  - Accept = in_valid & in_ready.
  - Take = out_valid & out_ready.
  - Both are evaluated at the rising edge.
- States (2-bit encoding):
  - EMPTY=0: occupancy 0, out_valid 0, in_ready 1.
  - ONE=1: occupancy 1, out_valid 1, in_ready 1.
  - FULL=2: occupancy 2, out_valid 1, in_ready 0.
- Transitions, with no flush:
  - EMPTY, accept -> ONE; main <= in.
  - ONE, accept & take -> ONE; main <= in.
  - ONE, accept & !take -> FULL; skid <= in.
  - ONE, !accept & take -> EMPTY.
  - FULL, take -> ONE; main <= skid.
  - FULL, no take -> FULL, hold.
  - All other cases hold.
- Latency: a pair accepted at edge N appears on out_* after edge N when the buffer was EMPTY, or when it was ONE with a simultaneous take.
- Ordering: strict FIFO. Skid data never overtakes main.
- out_pc and out_instr always show the main register. Their value is don't-care while out_valid=0, but must hold last value (no X).
- flush (highest priority after reset):
  - Next state is EMPTY regardless of accept or take.
  - A pair handshaked in the same cycle is discarded.
  - The main and skid data registers are not cleared.
- reset:
  - Next state EMPTY; out_valid=0; in_ready=1; occupancy=0.
  - out_pc=0; out_instr=0; skid data=0.
  - Overrides flush, accept and take.
- Reset or flush mid-operation (FULL or ONE): the entry is dropped; no partial entry survives.
- in_ready is a pure function of the registered state. Deasserting out_ready never changes in_ready in the same cycle.
- in_valid with in_ready=0: no state change. Fetch must hold its data.

Decomposition:
- definitions.vh, shared across the codebase:
  - `WORD and new `INSTR_WIDTH.
  - State encodings `FDB_EMPTY, `FDB_ONE, `FDB_FULL.
  - `CYCLE, used by the bench.
- One natural sub-module: enable_register, a WORD-parameterised D flip-flop with sync reset and load enable.
  - Instantiated for the main and skid stages (PC and instruction fields).
  - The control FSM stays in fetch_decode_buffer.

Test Plan:
1. Reset then stream: hold reset 1 cycle, then present PC 0,4,8 with instr 0x8B020020, 0xCB020020, 0xF8400020, out_ready=1 throughout -> out_pc 0,4,8 on consecutive cycles one cycle after each accept; in_ready stays 1; occupancy 1 each cycle.
2. Backpressure: out_ready=0, push PC 0x10 and 0x14 -> occupancy 2, in_ready=0, out_pc=0x10. In the third cycle hold in_valid with PC 0x18 -> not accepted. Raise out_ready -> out_pc sequence 0x10, 0x14, 0x18 with no loss or duplication.
3. Simultaneous accept and take in ONE: main=0x20; in the same cycle accept 0x24 and take 0x20 -> state ONE, out_pc=0x24, occupancy 1.
4. Flush in FULL with in_valid=1 (PC 0x40) -> next cycle out_valid=0, occupancy 0, in_ready=1. Next pushed PC 0x100 appears as head.
5. Reset mid-stream: in FULL, assert reset together with flush=0 and in_valid=1 -> next cycle out_valid=0, out_pc=0, out_instr=0, in_ready=1. Deassert reset after 1/5 cycle of the next period -> first accepted pair after deassertion is the first output.
6. Drain to empty: from ONE with out_ready=1 and in_valid=0 -> EMPTY next cycle; out_pc holds last value, out_valid=0.
